// File: rtl/fetch_pkg.sv
// Shared constants, fetch-queue entry type and PC alignment helper for the fetch stage.
package fetch_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order FIFO of fetched {pc, instr} entries; flush empties it in one cycle.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int QDEPTH = 2,
   parameter int CW     = $clog2(QDEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          enq,
   input  fetch_entry_t  enq_data,
   input  logic          deq,
   output fetch_entry_t  head,
   output logic [CW-1:0] count
);

   localparam int PW = $clog2(QDEPTH);

   fetch_entry_t  r_mem [QDEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (enq) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (deq) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (enq && !deq)      r_count <= r_count + 1'b1;
         else if (deq && !enq) r_count <= r_count - 1'b1;
      end
   end

   // NOTE: storage is not reset; count alone decides validity, so stale words are never seen.
   always_ff @(posedge clk) begin
      if (enq) r_mem[r_wr_ptr] <= enq_data;
   end

   assign head  = r_mem[r_rd_ptr];
   assign count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, queues fetched words, serves decode, handles redirects.
// Define FETCH_PERF_EN to add the perf_fetch_cnt / perf_stall_cnt counters.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              QDEPTH   = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     perf_fetch_cnt,
   output logic [31:0]     perf_stall_cnt
`endif
);

   localparam int CW = $clog2(QDEPTH) + 1;

   logic [XLEN-1:0] r_pc;
   logic [CW-1:0]   w_count;
   logic            w_not_empty;
   logic            w_full;
   logic            w_enq;
   logic            w_deq;
   fetch_entry_t    w_enq_data;
   fetch_entry_t    w_head;

   assign w_not_empty = (w_count != '0);
   assign w_full      = (w_count == CW'(QDEPTH));

   // Redirect masks the head so a wrong-path entry can never be accepted.
   assign if_valid   = w_not_empty & ~redirect_valid;
   assign w_deq      = if_valid & if_ready & ~redirect_valid;
   assign w_enq      = ~redirect_valid & (~w_full | w_deq);
   assign w_enq_data = '{pc: r_pc, instr: imem_rdata};

   always_ff @(posedge clk) begin
      if (reset)               r_pc <= RESET_PC;
      else if (redirect_valid) r_pc <= align_pc(redirect_pc);
      else if (w_enq)          r_pc <= r_pc + XLEN'(INSTR_BYTES);
   end

   assign imem_addr = r_pc;

   fetch_queue #(
      .QDEPTH (QDEPTH),
      .CW     (CW)
   ) u_queue (
      .clk      (clk),
      .reset    (reset),
      .flush    (redirect_valid),
      .enq      (w_enq),
      .enq_data (w_enq_data),
      .deq      (w_deq),
      .head     (w_head),
      .count    (w_count)
   );

   // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
   always_comb begin
      if_instr = '0;
      if_pc    = '0;
      if (if_valid) begin
         if_instr = w_head.instr;
         if_pc    = w_head.pc;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] r_perf_fetch_cnt;
   logic [31:0] r_perf_stall_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_perf_fetch_cnt <= '0;
         r_perf_stall_cnt <= '0;
      end else begin
         if (w_enq) r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
         if (w_full && !w_deq && !redirect_valid) r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
   end

   assign perf_fetch_cnt = r_perf_fetch_cnt;
   assign perf_stall_cnt = r_perf_stall_cnt;
`else
   // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a queue model.
module tb_fetch_unit;

   localparam int          QDEPTH   = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC (RESET_PC),
      .QDEPTH   (QDEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   // Combinational instruction memory with two fixed words and a hashed pattern elsewhere.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'hE04F_000F;
         32'h0000_0004: return 32'hE280_2005;
         default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
      endcase
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] mpc;
   logic [31:0] got[$];
`ifdef FETCH_PERF_EN
   logic [31:0] mfetch;
   logic [31:0] mstall;
`endif

   logic        exp_valid;
   logic        exp_head_known;
   logic [31:0] exp_addr;
   logic [31:0] exp_pc;
   logic [31:0] exp_instr;

   int n_cmp = 0;
   int n_err = 0;

   task automatic drive(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
      reset          = rst;
      redirect_valid = rv;
      redirect_pc    = rpc;
      if_ready       = rdy;
   endtask

   // Settle, derive expectations from the model, and log every handshake the DUT offers.
   task automatic observe();
      #2;
      exp_addr       = mpc;
      exp_valid      = (mq.size() != 0) && !redirect_valid;
      exp_head_known = exp_valid || (mq.size() == 0);
      exp_pc         = 32'h0;
      exp_instr      = 32'h0;
      if (exp_valid) begin
         exp_pc    = mq[0].pc;
         exp_instr = mq[0].instr;
      end
      if (if_valid === 1'b1 && if_ready === 1'b1) got.push_back(if_pc);
   endtask

   // Advance the model by one clock using the currently driven inputs, then clock the DUT.
   task automatic tick();
      logic d;
      logic f;
      if (reset) begin
         mq.delete();
         mpc = RESET_PC;
`ifdef FETCH_PERF_EN
         mfetch = 0;
         mstall = 0;
`endif
      end else if (redirect_valid) begin
         mq.delete();
         mpc = redirect_pc & ~32'h3;
      end else begin
         d = (mq.size() != 0) && if_ready;
         f = (mq.size() == QDEPTH);
`ifdef FETCH_PERF_EN
         if (f && !d) mstall = mstall + 1;
`endif
         if (d) void'(mq.pop_front());
         if (!f || d) begin
            mq.push_back('{pc: mpc, instr: mem_word(mpc)});
            mpc = mpc + 32'd4;
`ifdef FETCH_PERF_EN
            mfetch = mfetch + 1;
`endif
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      observe();
      n_cmp++; if (imem_addr !== RESET_PC) begin n_err++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
      n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", if_valid); end
      n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", if_pc); end
      n_cmp++; if (if_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", if_instr); end
   endtask

   task automatic test_basic();
      do_reset();
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         observe();
         n_cmp++; if (imem_addr !== 32'(i * 4)) begin n_err++; $display("FAIL basic_addr[%0d]: got %h want %h", i, imem_addr, 32'(i * 4)); end
         if (i == 0) begin
            n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid0: got %b want 0", if_valid); end
         end else begin
            n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid[%0d]: got %b want 1", i, if_valid); end
            n_cmp++; if (if_pc !== 32'((i - 1) * 4)) begin n_err++; $display("FAIL basic_pc[%0d]: got %h want %h", i, if_pc, 32'((i - 1) * 4)); end
         end
         if (i == 1) begin
            n_cmp++; if (if_instr !== 32'hE04F_000F) begin n_err++; $display("FAIL basic_instr1: got %h want E04F000F", if_instr); end
         end
         if (i == 2) begin
            n_cmp++; if (if_instr !== 32'hE280_2005) begin n_err++; $display("FAIL basic_instr2: got %h want E2802005", if_instr); end
         end
         tick();
      end
   endtask

   task automatic test_stall();
      do_reset();
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         observe();
         n_cmp++; if (imem_addr !== exp_addr) begin n_err++; $display("FAIL stall_addr[%0d]: got %h want %h", i, imem_addr, exp_addr); end
         if (i >= 2) begin
            n_cmp++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL stall_addr_stuck[%0d]: got %h want 8", i, imem_addr); end
         end
         if (i >= 1) begin
            n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'hE04F_000F) begin
               n_err++; $display("FAIL stall_head[%0d]: got v=%b pc=%h instr=%h want v=1 pc=0 instr=E04F000F", i, if_valid, if_pc, if_instr);
            end
         end
         tick();
      end
      got.delete();
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         observe();
         tick();
      end
      n_cmp++; if (got.size() != 4) begin n_err++; $display("FAIL stall_release_count: got %0d want 4", got.size()); end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         n_cmp++; if (got[i] !== 32'(i * 4)) begin n_err++; $display("FAIL stall_release_pc[%0d]: got %h want %h", i, got[i], 32'(i * 4)); end
      end
   endtask

   task automatic test_redirect();
      do_reset();
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      got.delete();
      drive(1'b0, 1'b1, 32'h40, 1'b1);
      observe();
      n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL redir_mask: got %b want 0", if_valid); end
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      observe();
      n_cmp++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL redir_addr: got %h want 00000040", imem_addr); end
      n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL redir_empty: got %b want 0", if_valid); end
      tick();
      observe();
      n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h40) begin n_err++; $display("FAIL redir_target: got v=%b pc=%h want v=1 pc=00000040", if_valid, if_pc); end
      n_cmp++; if (if_instr !== exp_instr) begin n_err++; $display("FAIL redir_instr: got %h want %h", if_instr, exp_instr); end
      tick();
      n_cmp++; if (got.size() == 0 || got[0] !== 32'h40) begin n_err++; $display("FAIL redir_first_delivered: got %h want 00000040", got.size() ? got[0] : 32'hX); end
   endtask

   task automatic test_align_b2b();
      drive(1'b0, 1'b1, 32'h43, 1'b1);
      observe();
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      observe();
      n_cmp++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL align_addr: got %h want 00000040", imem_addr); end
      tick();
      got.delete();
      drive(1'b0, 1'b1, 32'h80, 1'b1);
      observe();
      tick();
      drive(1'b0, 1'b1, 32'hC0, 1'b1);
      observe();
      n_cmp++; if (imem_addr !== 32'h80) begin n_err++; $display("FAIL b2b_first_addr: got %h want 00000080", imem_addr); end
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      observe();
      n_cmp++; if (imem_addr !== 32'hC0) begin n_err++; $display("FAIL b2b_last_addr: got %h want 000000C0", imem_addr); end
      tick();
      for (int i = 0; i < 2; i++) begin
         observe();
         tick();
      end
      n_cmp++; if (got.size() != 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", got.size()); end
      if (got.size() == 2) begin
         n_cmp++; if (got[0] !== 32'hC0 || got[1] !== 32'hC4) begin n_err++; $display("FAIL b2b_stream: got %h,%h want 000000C0,000000C4", got[0], got[1]); end
      end
   endtask

   task automatic test_wrap();
      got.delete();
      drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
      observe();
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         observe();
         if (i == 1) begin
            n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr: got %h want 00000000", imem_addr); end
         end
         tick();
      end
      n_cmp++; if (got.size() < 2 || got[0] !== 32'hFFFF_FFFC || got[1] !== 32'h0) begin
         n_err++; $display("FAIL wrap_stream: got n=%0d first=%h second=%h want FFFFFFFC,00000000",
                           got.size(), got.size() > 0 ? got[0] : 32'hX, got.size() > 1 ? got[1] : 32'hX);
      end
   endtask

`ifdef FETCH_PERF_EN
   task automatic test_perf();
      do_reset();
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 10; i++) tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      observe();
      n_cmp++; if (perf_fetch_cnt !== mfetch || perf_fetch_cnt !== 32'd11) begin n_err++; $display("FAIL perf_fetch: got %0d want %0d", perf_fetch_cnt, mfetch); end
      n_cmp++; if (perf_stall_cnt !== mstall || perf_stall_cnt !== 32'd3) begin n_err++; $display("FAIL perf_stall: got %0d want %0d", perf_stall_cnt, mstall); end
      do_reset();
      observe();
      n_cmp++; if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
         n_err++; $display("FAIL perf_reset: got fetch=%0d stall=%0d want 0,0", perf_fetch_cnt, perf_stall_cnt);
      end
   endtask
`endif

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom % 100) == 0, ($urandom % 16) == 0, $urandom, ($urandom % 4) != 0);
         observe();
         n_cmp++; if (imem_addr !== exp_addr) begin n_err++; $display("FAIL rand_addr[%0d]: got %h want %h", i, imem_addr, exp_addr); end
         n_cmp++; if (if_valid !== exp_valid) begin n_err++; $display("FAIL rand_valid[%0d]: got %b want %b", i, if_valid, exp_valid); end
         if (exp_head_known) begin
            n_cmp++; if (if_pc !== exp_pc || if_instr !== exp_instr) begin
               n_err++; $display("FAIL rand_head[%0d]: got pc=%h instr=%h want pc=%h instr=%h", i, if_pc, if_instr, exp_pc, exp_instr);
            end
         end
`ifdef FETCH_PERF_EN
         n_cmp++; if (perf_fetch_cnt !== mfetch || perf_stall_cnt !== mstall) begin
            n_err++; $display("FAIL rand_perf[%0d]: got %0d/%0d want %0d/%0d", i, perf_fetch_cnt, perf_stall_cnt, mfetch, mstall);
         end
`endif
         tick();
      end
   endtask

   initial begin
      mpc = RESET_PC;
`ifdef FETCH_PERF_EN
      mfetch = 0;
      mstall = 0;
`endif
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      test_reset();
      test_basic();
      test_stall();
      test_redirect();
      test_align_b2b();
      test_wrap();
`ifdef FETCH_PERF_EN
      test_perf();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
